// File: rtl/twiddle_seq_gen.sv
// Radix-2 DIF FFT twiddle sequencer: streams W_N^k for one stage per start request,
// built from a quarter-wave cosine table with octant/quadrant symmetry.
module twiddle_seq_gen #(
  parameter int unsigned N       = 128,
  parameter int unsigned W_WIDTH = 16,
  parameter int unsigned LOG2N   = $clog2(N),
  parameter int unsigned SW      = $clog2(LOG2N)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [SW-1:0]             stage,
  input  logic                      w_ready,
  output logic signed [W_WIDTH-1:0] W_real,
  output logic signed [W_WIDTH-1:0] W_imag,
  output logic                      w_valid,
  output logic                      w_last,
  output logic                      busy,
  output logic                      err
);

  localparam int unsigned AW = LOG2N - 1;
  localparam logic [AW-1:0] Quarter = AW'(N / 4);
  localparam logic [AW:0]   Half    = (AW + 1)'(N / 2);
  localparam logic [AW-1:0] LastJ   = AW'(N / 2 - 1);

  // round(cos(2*pi*i/N) * 2^(W_WIDTH-2)) via a Q30 Taylor series, evaluated at elaboration.
  function automatic logic [W_WIDTH-1:0] cos_q(input int unsigned i);
    longint x, x2, term, sum;
    x    = (64'sd6746518852 * longint'(i)) / longint'(N);
    x2   = (x * x) >>> 30;
    term = 64'sd1 <<< 30;
    sum  = term;
    for (int n = 1; n <= 12; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    cos_q = W_WIDTH'(((sum <<< (W_WIDTH - 2)) + (64'sd1 <<< 29)) >>> 30);
  endfunction

  logic signed [W_WIDTH-1:0] cos_tab [N/4+1];

  for (genvar g = 0; g <= int'(N / 4); g++) begin : g_rom
    localparam logic [W_WIDTH-1:0] CosVal = cos_q(g);
    assign cos_tab[g] = CosVal;
  end

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] j_q, j_d;
  logic [SW-1:0] s_q, s_d;
  logic          advance, issue, err_d;
  logic [AW-1:0] idx, k;
  logic [SW-1:0] sel;

  // P0/P1 pipeline registers
  logic          v0_q, last0_q, neg0_q;
  logic [AW-1:0] addr_r0_q, addr_i0_q;
  logic          v1_q, last1_q, neg1_q;
  logic signed [W_WIDTH-1:0] rom_r1_q, rom_i1_q;

  logic          hi;
  logic [AW-1:0] addr_r_d, addr_i_d;

  assign advance = ~w_valid | w_ready;
  assign busy    = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    s_d     = s_q;
    issue   = 1'b0;
    idx     = j_q;
    sel     = s_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (32'(stage) < LOG2N) begin
            // Item 0 enters P0 on the accept edge; j then holds the next index.
            state_d = StRun;
            s_d     = stage;
            sel     = stage;
            idx     = '0;
            j_d     = AW'(1);
            issue   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (advance) begin
          issue = 1'b1;
          if (j_q == LastJ) begin
            state_d = StDrain;
          end else begin
            j_d = j_q + AW'(1);
          end
        end
      end
      StDrain: begin
        if (w_valid && w_ready && w_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // (j mod (N >> (s+1))) << s is the same as j << s truncated to AW bits.
  always_comb begin
    k        = idx << sel;
    hi       = (k > Quarter);
    addr_r_d = hi ? AW'(Half - {1'b0, k}) : k;
    addr_i_d = hi ? (k - Quarter) : (Quarter - k);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      j_q     <= '0;
      s_q     <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      s_q     <= s_d;
      err     <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q      <= 1'b0;
      last0_q   <= 1'b0;
      neg0_q    <= 1'b0;
      addr_r0_q <= '0;
      addr_i0_q <= '0;
      v1_q      <= 1'b0;
      last1_q   <= 1'b0;
      neg1_q    <= 1'b0;
      rom_r1_q  <= '0;
      rom_i1_q  <= '0;
      w_valid   <= 1'b0;
      w_last    <= 1'b0;
      W_real    <= '0;
      W_imag    <= '0;
    end else if (advance) begin
      v0_q      <= issue;
      last0_q   <= issue && (idx == LastJ);
      neg0_q    <= hi;
      addr_r0_q <= addr_r_d;
      addr_i0_q <= addr_i_d;
      v1_q      <= v0_q;
      last1_q   <= last0_q;
      neg1_q    <= neg0_q;
      rom_r1_q  <= cos_tab[addr_r0_q];
      rom_i1_q  <= cos_tab[addr_i0_q];
      w_valid   <= v1_q;
      w_last    <= last1_q;
      W_real    <= neg1_q ? -rom_r1_q : rom_r1_q;
      W_imag    <= -rom_i1_q;
    end
  end

endmodule

// File: tb/tb_twiddle_seq_gen.sv
// Self-checking bench for twiddle_seq_gen: trigonometric reference model, per-cycle monitor,
// randomized backpressure and stage selection, plus directed corner cases.
module tb_twiddle_seq_gen;

  localparam int N     = 128;
  localparam int WW    = 16;
  localparam int HALFN = N / 2;
  localparam real PI   = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [2:0]           stage = '0;
  logic                 w_ready = 1'b1;
  logic signed [WW-1:0] W_real, W_imag;
  logic                 w_valid, w_last, busy, err;

  twiddle_seq_gen #(.N(N), .W_WIDTH(WW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stage   (stage),
    .w_ready (w_ready),
    .W_real  (W_real),
    .W_imag  (W_imag),
    .w_valid (w_valid),
    .w_last  (w_last),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // monitor / driver state
  int cur_stage = 0;
  int exp_idx = 0;
  int err_count = 0;
  bit prev_stall = 0;
  bit after_last = 0;
  bit rand_ready = 0;
  int ready_pct = 50;
  bit spam = 0;
  int first_re = 0, first_im = 0;
  int prev_re = 0, prev_im = 0;
  bit prev_last = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else return -$rtoi(-x + 0.5);
  endfunction

  // W_N^k = cos(2*pi*k/N) - i*sin(2*pi*k/N), k from the stage's butterfly spacing.
  task automatic model(input int s, input int j, output int re, output int im);
    int  k;
    real th;
    k  = (j % (N >> (s + 1))) << s;
    th = 2.0 * PI * real'(k) / real'(N);
    re = rnd($cos(th) * 16384.0);
    im = rnd(-$sin(th) * 16384.0);
  endtask

  // One cycle: monitor at the falling edge, then drive just after the rising edge.
  task automatic tick();
    int re, im;
    @(negedge clk);
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_valid", w_valid, 1);
        chk("stall_real", W_real, prev_re);
        chk("stall_imag", W_imag, prev_im);
        chk("stall_last", w_last, prev_last);
      end
      if (after_last) begin
        chk("busy_after_last", busy, 0);
        after_last = 0;
      end
      if (w_valid && w_ready) begin
        if (exp_idx >= HALFN) begin
          chk("extra_item", exp_idx, HALFN - 1);
        end else begin
          model(cur_stage, exp_idx, re, im);
          chk($sformatf("real s%0d j%0d", cur_stage, exp_idx), W_real, re);
          chk($sformatf("imag s%0d j%0d", cur_stage, exp_idx), W_imag, im);
          chk($sformatf("last s%0d j%0d", cur_stage, exp_idx), w_last, exp_idx == HALFN - 1);
          if (exp_idx == 0) begin
            first_re = W_real;
            first_im = W_imag;
          end
          if (w_last) begin
            chk("busy_at_last", busy, 1);
            after_last = 1;
          end
          exp_idx++;
        end
      end
      if (err) err_count++;
      prev_stall = w_valid && !w_ready;
      prev_re    = W_real;
      prev_im    = W_imag;
      prev_last  = w_last;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    if (rand_ready) w_ready = ($urandom_range(0, 99) < ready_pct);
    if (spam) begin
      start = busy;
      stage = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic launch(input int s);
    cur_stage = s;
    exp_idx   = 0;
    stage     = 3'(s);
    start     = 1'b1;
    tick();
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(exp_idx == HALFN && !busy && !after_last) && n < 2000) begin
      tick();
      n++;
    end
    chk({name, "_done"}, exp_idx, HALFN);
  endtask

  initial begin
    int re, im, n, e0;

    // model pins
    model(0, 0, re, im);  chk("pin s0j0 re", re, 16384);   chk("pin s0j0 im", im, 0);
    model(0, 16, re, im); chk("pin s0j16 re", re, 11585);  chk("pin s0j16 im", im, -11585);
    model(0, 32, re, im); chk("pin s0j32 re", re, 0);      chk("pin s0j32 im", im, -16384);
    model(0, 48, re, im); chk("pin s0j48 re", re, -11585); chk("pin s0j48 im", im, -11585);
    model(1, 8, re, im);  chk("pin s1j8 re", re, 11585);   chk("pin s1j8 im", im, -11585);
    model(1, 40, re, im); chk("pin s1j40 re", re, 11585);  chk("pin s1j40 im", im, -11585);
    model(1, 31, re, im); chk("pin s1j31 re", re, -16305); chk("pin s1j31 im", im, -1606);
    model(6, 37, re, im); chk("pin s6j37 re", re, 16384);  chk("pin s6j37 im", im, 0);

    // reset state
    #3;
    chk("rst w_valid", w_valid, 0); chk("rst w_last", w_last, 0);
    chk("rst busy", busy, 0);       chk("rst err", err, 0);
    chk("rst W_real", W_real, 0);   chk("rst W_imag", W_imag, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // stage 0, ready high: latency and full stream
    launch(0);
    n = 1;
    while (!w_valid && n < 20) begin
      tick();
      n++;
    end
    chk("first_valid_latency", n, 3);
    wait_done("stage0");

    launch(1);
    wait_done("stage1");
    launch(6);
    wait_done("stage6");

    // backpressure on stage 0, then random stages with random ready density
    rand_ready = 1;
    launch(0);
    wait_done("bp_stage0");
    for (int t = 0; t < 6; t++) begin
      ready_pct = $urandom_range(20, 90);
      launch($urandom_range(0, 6));
      wait_done("rand_stream");
    end
    rand_ready = 0;
    w_ready    = 1'b1;
    tick();

    // illegal stage
    e0 = err_count;
    stage = 3'd7;
    start = 1'b1;
    tick();
    chk("illegal err", err, 1);
    chk("illegal busy", busy, 0);
    tick();
    chk("illegal err_once", err, 0);
    repeat (4) tick();
    chk("illegal err_count", err_count - e0, 1);
    chk("illegal no_valid", w_valid, 0);

    // starts while busy (including the final handshake cycle) are ignored
    e0 = err_count;
    rand_ready = 1;
    ready_pct  = 60;
    launch(0);
    spam = 1;
    wait_done("overlap");
    spam = 0;
    rand_ready = 0;
    w_ready    = 1'b1;
    start      = 1'b0;
    repeat (8) tick();
    chk("overlap no_err", err_count - e0, 0);
    chk("overlap idle", busy, 0);
    chk("overlap count", exp_idx, HALFN);

    // async reset mid-stream
    launch(0);
    n = 0;
    while (exp_idx < 20 && n < 200) begin
      tick();
      n++;
    end
    chk("reach_item20", exp_idx, 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst w_valid", w_valid, 0); chk("midrst W_real", W_real, 0);
    chk("midrst W_imag", W_imag, 0);   chk("midrst busy", busy, 0);
    chk("midrst w_last", w_last, 0);
    prev_stall = 0;
    after_last = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("postrst idle", w_valid, 0);
    first_re = 0;
    first_im = 99;
    launch(0);
    wait_done("postrst");
    chk("postrst first_re", first_re, 16384);
    chk("postrst first_im", first_im, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
